ucie_ctl_adapter_rdi_tx: RTL and testbench
==========================================

Name: ucie_ctl_adapter_rdi_tx

Overview:
- Adapter-side RDI transmit stage, directly upstream of the PHY data-transfer block.
- Buffers flit chunks from the FDI/adapter core in a small FIFO.
- Drives lp_irdy/lp_valid/lp_data onto RDI and advances only on the PHY's pl_trdy.
- Handles link enable/disable with a drain phase, plus a synchronous flush.

Parameters:
- NBYTES, 8: RDI data width in bytes; data bus is NBYTES*8 bits.
- DEPTH, 4: FIFO entries; power of 2, >= 2.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_enable  input  1  link-active control from adapter FSM
- i_flush  input  1  synchronous FIFO flush, single-cycle pulse
- i_fdi_lp_valid  input  1  upstream data valid
- i_fdi_lp_data  input  NBYTES*8  upstream data
- o_fdi_pl_trdy  output  1  FIFO can accept this cycle
- i_rdi_pl_trdy  input  1  PHY ready
- o_rdi_lp_irdy  output  1  adapter ready on RDI
- o_rdi_lp_valid  output  1  RDI data valid
- o_rdi_lp_data  output  NBYTES*8  RDI data (FIFO head)
- o_fifo_level  output  $clog2(DEPTH)+1  current occupancy
- o_drop_err  output  1  sticky: upstream valid presented while not accepting in DISABLED/DRAIN

Behaviour:
- Reset: state DISABLED; FIFO empty (pointers 0); all outputs 0, including o_fifo_level and o_drop_err.
- Push = i_fdi_lp_valid && o_fdi_pl_trdy.
- Pop = o_rdi_lp_valid && i_rdi_pl_trdy.
- o_fdi_pl_trdy = (state IDLE or SENDING) && level != DEPTH. No write-through when full, even with a simultaneous pop.
- o_rdi_lp_valid = level != 0 && state in {SENDING, DRAIN}.
- o_rdi_lp_irdy = 1 in IDLE, SENDING, DRAIN; 0 in DISABLED.
- o_rdi_lp_data = head entry when o_rdi_lp_valid, else 0.
- Latency: entry pushed in cycle N is visible on RDI in cycle N+1 if the FIFO was empty.
- Ordering: strict FIFO; pointers wrap modulo DEPTH. Level +1 on push only, -1 on pop only, unchanged on both.
- States:
  - DISABLED: all handshakes low. i_enable=1 -> IDLE.
  - IDLE: FIFO empty, accepting. Push -> SENDING. !i_enable -> DISABLED.
  - SENDING: non-empty. Level reaches 0 (pop, no push) -> IDLE. !i_enable && level after this cycle > 0 -> DRAIN. !i_enable && level becomes 0 -> DISABLED.
  - DRAIN: no pushes accepted; keep popping on pl_trdy. Level reaches 0 -> DISABLED. i_enable re-asserted -> SENDING (or IDLE if empty).
- i_flush has priority over push/pop in the same cycle:
  - Level -> 0 next cycle, pointers -> 0, o_drop_err cleared.
  - Next state: IDLE if i_enable, else DISABLED.
  - o_rdi_lp_valid drops the cycle after the flush.
- o_drop_err sets when i_fdi_lp_valid=1 in DISABLED or DRAIN; cleared only by reset or flush. Backpressure when full is not an error.
- Reset mid-transfer: immediate return to reset values; FIFO content discarded.

Optional Feature:
- Macro UCIE_CTL_RDI_TX_STALL_CNT_EN.
- Defined: adds output o_stall_cnt[15:0].
  - Increments each cycle o_rdi_lp_valid=1 && i_rdi_pl_trdy=0.
  - Saturates at 16'hFFFF; cleared by reset and i_flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, enable=1, push 0x11,0x22,0x33 back-to-back with pl_trdy=1 -> lp_valid high cycles 2-4; lp_data 0x11,0x22,0x33 in order; then IDLE, level 0.
- pl_trdy=0, push 5 entries with DEPTH=4 -> o_fdi_pl_trdy low after 4th accept, level=4. Raise pl_trdy -> 4 entries emerge in order; 5th is accepted once space frees.
- Fill 3 entries, deassert i_enable with pl_trdy=1 -> state DRAIN, fdi_pl_trdy=0, 3 pops, then DISABLED. fdi_lp_valid during DRAIN -> o_drop_err=1.
- Level=2 with push and flush in the same cycle -> next cycle level=0, lp_valid=0, o_drop_err=0, state IDLE.
- Level=1 with push and pop in the same cycle -> level stays 1; data order preserved across pointer wrap (push 6 entries through DEPTH=4 with continuous pop).
- With UCIE_CTL_RDI_TX_STALL_CNT_EN: hold pl_trdy=0 for 10 cycles with lp_valid=1 -> o_stall_cnt=10. Flush -> 0.

Source files
------------

// File: rtl/ucie_ctl_adapter_rdi_tx.sv
// Adapter RDI TX stage: DEPTH-entry FIFO from FDI to RDI; an empty-FIFO push shows on RDI next cycle, and RDI advances only on pl_trdy.
// Upstream is backpressured via o_fdi_pl_trdy; define UCIE_CTL_RDI_TX_STALL_CNT_EN to add the o_stall_cnt stall counter.
module ucie_ctl_adapter_rdi_tx #(
   parameter int NBYTES = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_enable,
   input  logic                      i_flush,
   input  logic                      i_fdi_lp_valid,
   input  logic [NBYTES*8-1:0]       i_fdi_lp_data,
   output logic                      o_fdi_pl_trdy,
   input  logic                      i_rdi_pl_trdy,
   output logic                      o_rdi_lp_irdy,
   output logic                      o_rdi_lp_valid,
   output logic [NBYTES*8-1:0]       o_rdi_lp_data,
   output logic [$clog2(DEPTH):0]    o_fifo_level,
   output logic                      o_drop_err
`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
   ,
   output logic [15:0]               o_stall_cnt
`endif
);

   localparam int DW = NBYTES * 8;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

   typedef enum logic [1:0] {
      ST_DISABLED,
      ST_IDLE,
      ST_SENDING,
      ST_DRAIN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic [AW:0]   level_nxt;
   logic          push;
   logic          pop;
   logic          drop_err;

   // Handshake outputs depend only on registered state and occupancy.
   always_comb begin
      o_fdi_pl_trdy  = 1'b0;
      o_rdi_lp_irdy  = 1'b0;
      o_rdi_lp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            o_rdi_lp_irdy = 1'b1;
            o_fdi_pl_trdy = (level != LVL_FULL);
         end
         ST_SENDING: begin
            o_rdi_lp_irdy  = 1'b1;
            o_fdi_pl_trdy  = (level != LVL_FULL);
            o_rdi_lp_valid = (level != '0);
         end
         ST_DRAIN: begin
            o_rdi_lp_irdy  = 1'b1;
            o_rdi_lp_valid = (level != '0);
         end
         default: begin
            o_rdi_lp_irdy = 1'b0;
         end
      endcase
   end

   // Flush wins over any handshake in the same cycle.
   always_comb begin
      push      = i_fdi_lp_valid && o_fdi_pl_trdy && !i_flush;
      pop       = o_rdi_lp_valid && i_rdi_pl_trdy && !i_flush;
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + 1'b1;
      end else if (pop && !push) begin
         level_nxt = level - 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = i_enable ? ST_IDLE : ST_DISABLED;
      end else begin
         case (state)
            ST_DISABLED: begin
               if (i_enable) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
               if (!i_enable)  state_nxt = (level_nxt != '0) ? ST_DRAIN : ST_DISABLED;
               else if (push)  state_nxt = ST_SENDING;
            end
            ST_SENDING: begin
               if (!i_enable)               state_nxt = (level_nxt != '0) ? ST_DRAIN : ST_DISABLED;
               else if (level_nxt == '0)    state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
               if (i_enable)                state_nxt = (level_nxt != '0) ? ST_SENDING : ST_IDLE;
               else if (level_nxt == '0)    state_nxt = ST_DISABLED;
            end
            default: state_nxt = ST_DISABLED;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_DISABLED;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         drop_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_err <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            if (i_fdi_lp_valid && (state == ST_DISABLED || state == ST_DRAIN)) begin
               drop_err <= 1'b1;
            end
         end
      end
   end

   // Storage needs no reset: entries are only visible while level covers them.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_fdi_lp_data;
   end

   assign o_rdi_lp_data = o_rdi_lp_valid ? mem[rd_ptr] : '0;
   assign o_fifo_level  = level;
   assign o_drop_err    = drop_err;

`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt <= '0;
      end else if (i_flush) begin
         stall_cnt <= '0;
      end else if (o_rdi_lp_valid && !i_rdi_pl_trdy && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ucie_ctl_adapter_rdi_tx.sv
// Directed bench for ucie_ctl_adapter_rdi_tx with a queue scoreboard on the RDI side.
module tb_ucie_ctl_adapter_rdi_tx;

   localparam int NBYTES = 8;
   localparam int DEPTH  = 4;
   localparam int DW     = NBYTES * 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_enable;
   logic          i_flush;
   logic          i_fdi_lp_valid;
   logic [DW-1:0] i_fdi_lp_data;
   logic          o_fdi_pl_trdy;
   logic          i_rdi_pl_trdy;
   logic          o_rdi_lp_irdy;
   logic          o_rdi_lp_valid;
   logic [DW-1:0] o_rdi_lp_data;
   logic [LW-1:0] o_fifo_level;
   logic          o_drop_err;
`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
   logic [15:0]   o_stall_cnt;
`endif

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_q [$];

   ucie_ctl_adapter_rdi_tx #(
      .NBYTES(NBYTES),
      .DEPTH (DEPTH)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_enable       (i_enable),
      .i_flush        (i_flush),
      .i_fdi_lp_valid (i_fdi_lp_valid),
      .i_fdi_lp_data  (i_fdi_lp_data),
      .o_fdi_pl_trdy  (o_fdi_pl_trdy),
      .i_rdi_pl_trdy  (i_rdi_pl_trdy),
      .o_rdi_lp_irdy  (o_rdi_lp_irdy),
      .o_rdi_lp_valid (o_rdi_lp_valid),
      .o_rdi_lp_data  (o_rdi_lp_data),
      .o_fifo_level   (o_fifo_level),
      .o_drop_err     (o_drop_err)
`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
      ,
      .o_stall_cnt    (o_stall_cnt)
`endif
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: settle after the inputs change, update the scoreboard from the
   // handshakes the DUT shows, then advance to the next falling edge.
   task automatic tick();
      logic [DW-1:0] exp_d;
      #1;
      if (i_flush) begin
         exp_q.delete();
      end else begin
         if (i_fdi_lp_valid && o_fdi_pl_trdy) exp_q.push_back(i_fdi_lp_data);
         if (o_rdi_lp_valid && i_rdi_pl_trdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop", 64'(o_rdi_lp_data), 64'hDEAD);
            end else begin
               exp_d = exp_q.pop_front();
               chk("rdi_data", 64'(o_rdi_lp_data), 64'(exp_d));
            end
         end
      end
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      i_fdi_lp_valid = 1'b1;
      i_fdi_lp_data  = d;
      tick();
      i_fdi_lp_valid = 1'b0;
   endtask

   initial begin
      i_rst_n        = 1'b0;
      i_enable       = 1'b0;
      i_flush        = 1'b0;
      i_fdi_lp_valid = 1'b0;
      i_fdi_lp_data  = '0;
      i_rdi_pl_trdy  = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd0);
      chk("rst_irdy",     64'(o_rdi_lp_irdy), 64'd0);
      chk("rst_valid",    64'(o_rdi_lp_valid), 64'd0);
      chk("rst_data",     64'(o_rdi_lp_data), 64'd0);
      chk("rst_level",    64'(o_fifo_level), 64'd0);
      chk("rst_drop_err", 64'(o_drop_err), 64'd0);
      i_rst_n = 1'b1;

      // Back-to-back streaming with a ready PHY.
      i_enable = 1'b1;
      tick();
      chk("idle_irdy", 64'(o_rdi_lp_irdy), 64'd1);
      chk("idle_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd1);
      i_rdi_pl_trdy = 1'b1;
      push_one(64'h11);
      chk("lat1_valid", 64'(o_rdi_lp_valid), 64'd1);
      chk("lat1_level", 64'(o_fifo_level), 64'd1);
      push_one(64'h22);
      push_one(64'h33);
      chk("stream_level", 64'(o_fifo_level), 64'd1);
      tick();
      chk("stream_end_level", 64'(o_fifo_level), 64'd0);
      chk("stream_end_valid", 64'(o_rdi_lp_valid), 64'd0);
      chk("stream_end_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd1);
      chk("stream_sb_empty", 64'(exp_q.size()), 64'd0);

      // Fill to DEPTH with a stalled PHY, then release it.
      i_rdi_pl_trdy = 1'b0;
      for (int i = 1; i <= 4; i++) push_one(64'hA0 + 64'(i));
      chk("full_level", 64'(o_fifo_level), 64'd4);
      chk("full_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd0);
      push_one(64'hA5);
      chk("full_hold_level", 64'(o_fifo_level), 64'd4);
      i_rdi_pl_trdy = 1'b1;
      push_one(64'hA5);
      chk("full_no_wt_level", 64'(o_fifo_level), 64'd3);
      chk("space_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd1);
      push_one(64'hA5);
      chk("a5_level", 64'(o_fifo_level), 64'd3);
      for (int k = 0; k < 8 && o_fifo_level != 0; k++) tick();
      chk("full_drained_level", 64'(o_fifo_level), 64'd0);
      chk("full_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("bp_no_drop_err", 64'(o_drop_err), 64'd0);

      // Disable with data queued: drain phase.
      i_rdi_pl_trdy = 1'b0;
      for (int i = 1; i <= 3; i++) push_one(64'hB0 + 64'(i));
      chk("pre_drain_level", 64'(o_fifo_level), 64'd3);
      i_enable      = 1'b0;
      i_rdi_pl_trdy = 1'b1;
      tick();
      chk("drain_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd0);
      chk("drain_valid", 64'(o_rdi_lp_valid), 64'd1);
      chk("drain_irdy", 64'(o_rdi_lp_irdy), 64'd1);
      chk("drain_level", 64'(o_fifo_level), 64'd2);
      push_one(64'hEE);
      chk("drain_drop_err", 64'(o_drop_err), 64'd1);
      chk("drain_level2", 64'(o_fifo_level), 64'd1);
      tick();
      chk("disabled_irdy", 64'(o_rdi_lp_irdy), 64'd0);
      chk("disabled_valid", 64'(o_rdi_lp_valid), 64'd0);
      chk("disabled_level", 64'(o_fifo_level), 64'd0);
      chk("disabled_drop_sticky", 64'(o_drop_err), 64'd1);
      chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);

      // Flush colliding with a push.
      i_enable = 1'b1;
      tick();
      i_rdi_pl_trdy = 1'b0;
      push_one(64'hC1);
      push_one(64'hC2);
      chk("pre_flush_level", 64'(o_fifo_level), 64'd2);
      i_flush = 1'b1;
      push_one(64'hC3);
      i_flush = 1'b0;
      chk("flush_level", 64'(o_fifo_level), 64'd0);
      chk("flush_valid", 64'(o_rdi_lp_valid), 64'd0);
      chk("flush_drop_err", 64'(o_drop_err), 64'd0);
      chk("flush_idle_fdi_trdy", 64'(o_fdi_pl_trdy), 64'd1);

      // Simultaneous push/pop at level 1, wrapping the pointers.
      push_one(64'hD0);
      i_rdi_pl_trdy = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         push_one(64'hD0 + 64'(i));
         chk("pushpop_level", 64'(o_fifo_level), 64'd1);
      end
      tick();
      chk("wrap_level", 64'(o_fifo_level), 64'd0);
      chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of a transfer.
      i_rdi_pl_trdy = 1'b0;
      push_one(64'hF0);
      push_one(64'hF1);
      i_rst_n = 1'b0;
      #1;
      chk("arst_level", 64'(o_fifo_level), 64'd0);
      chk("arst_valid", 64'(o_rdi_lp_valid), 64'd0);
      chk("arst_irdy", 64'(o_rdi_lp_irdy), 64'd0);
      chk("arst_data", 64'(o_rdi_lp_data), 64'd0);
      exp_q.delete();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();

      // PHY stall for 10 cycles with valid data.
      push_one(64'hE0);
      for (int i = 0; i < 10; i++) tick();
`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
      chk("stall_cnt_10", 64'(o_stall_cnt), 64'd10);
`endif
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
`ifdef UCIE_CTL_RDI_TX_STALL_CNT_EN
      chk("stall_cnt_flush", 64'(o_stall_cnt), 64'd0);
`endif
      chk("final_level", 64'(o_fifo_level), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
